// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        VRD  = 3'd2,
        VCHK = 3'd3,
        RUN  = 3'd4,
        FAIL = 3'd5
    } state_e;

    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_SUM   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Program stream plus instruction-memory external port; the loader is the master.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;

    modport master (
        input  s_valid, s_data, rdata_ext,
        output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );

    modport slave (
        output s_valid, s_data, rdata_ext,
        input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );
endinterface

// File: rtl/imem_boot_loader_checksum.sv
// Modular (wrap-around) word accumulator with synchronous clear.
module boot_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory, optionally reads it back
// against a running checksum, then releases the CPU.
module imem_boot_loader #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = boot_pkg::WORD_BYTES,
    parameter int MAX_WORDS  = 128,
    parameter int CNT_W      = 8,
    parameter int VERIFY     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_words,
    imem_boot_loader_if.master bus,
    output logic               cpu_enable,
    output logic               busy,
    output logic               error,
    output logic [1:0]         err_code
);
    import boot_pkg::*;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  rdx_q, rdx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;
    logic              ren_dly_q;
    logic [1:0]        err_q, err_d;
    logic              sum_clr, sum_add, rsum_add;
    logic              len_ok;
    logic [DATA_W-1:0] sum, rsum;

    assign len_ok   = (num_words != '0) && (num_words <= CNT_W'(MAX_WORDS));
    assign rsum_add = ren_dly_q && (state_q == VRD);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        rdx_d   = rdx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        err_d   = err_q;
        sum_clr = 1'b0;
        sum_add = 1'b0;

        case (state_q)
            IDLE, FAIL: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = '0;
                end else if (start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        n_d     = num_words;
                        idx_d   = '0;
                        rdx_d   = '0;
                        sum_clr = 1'b1;
                        err_d   = '0;
                    end else begin
                        state_d = FAIL;
                        err_d   = ERR_LEN;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = FAIL;
                    err_d   = ERR_ABORT;
                end else if (bus.s_valid) begin
                    wen_d   = 1'b1;
                    addr_d  = ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);
                    wdata_d = bus.s_data;
                    idx_d   = idx_q + CNT_W'(1);
                    sum_add = 1'b1;
                    if (idx_q + CNT_W'(1) == n_q) begin
                        state_d = (VERIFY != 0) ? VRD : RUN;
                    end
                end
            end
            VRD: begin
                // Leave only once the last read has been issued and its data cycle is underway.
                if (abort) begin
                    state_d = FAIL;
                    err_d   = ERR_ABORT;
                end else if (rdx_q != n_q) begin
                    ren_d  = 1'b1;
                    addr_d = ADDR_W'(rdx_q) * ADDR_W'(WORD_BYTES);
                    rdx_d  = rdx_q + CNT_W'(1);
                end else if (!ren_q) begin
                    state_d = VCHK;
                end
            end
            VCHK: begin
                if (abort) begin
                    state_d = FAIL;
                    err_d   = ERR_ABORT;
                end else if (rsum == sum) begin
                    state_d = RUN;
                end else begin
                    state_d = FAIL;
                    err_d   = ERR_SUM;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            rdx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            ren_dly_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            rdx_q     <= rdx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            ren_dly_q <= ren_q;
            err_q     <= err_d;
        end
    end

    boot_checksum #(.DATA_W(DATA_W)) u_sum (
        .clk    (clk),
        .rst    (rst),
        .clr    (sum_clr),
        .add_en (sum_add),
        .din    (bus.s_data),
        .sum    (sum)
    );

    boot_checksum #(.DATA_W(DATA_W)) u_rsum (
        .clk    (clk),
        .rst    (rst),
        .clr    (sum_clr),
        .add_en (rsum_add),
        .din    (bus.rdata_ext),
        .sum    (rsum)
    );

    assign bus.s_ready   = (state_q == LOAD);
    assign bus.addr_ext  = addr_q;
    assign bus.wen_ext   = wen_q;
    assign bus.ren_ext   = ren_q;
    assign bus.wdata_ext = wdata_q;
    assign cpu_enable    = (state_q == RUN);
    assign busy          = (state_q == LOAD) || (state_q == VRD) || (state_q == VCHK);
    assign error         = (state_q == FAIL);
    assign err_code      = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: vector table of whole loads plus hand-written corner sequences.
module tb_imem_boot_loader;
    import boot_pkg::*;

    typedef struct {
        int         n;
        int         gap;
        bit         corrupt;
        bit         exp_run;
        logic [1:0] exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] num_words;
    logic       cpu_enable;
    logic       busy;
    logic       error;
    logic [1:0] err_code;
    bit         corrupt;
    int         total = 0;
    int         bad = 0;

    logic [31:0] mem [0:127];
    logic [31:0] img [0:2];
    logic [63:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [63:0] rd_addr_q [$];
    vec_t        vecs [7];

    imem_boot_loader_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    imem_boot_loader #(
        .ADDR_W(64), .DATA_W(32), .WORD_BYTES(4),
        .MAX_WORDS(128), .CNT_W(8), .VERIFY(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .bus        (bus),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory model; optionally flips bit 0 of the word at byte address 4 on readback.
    always @(posedge clk) begin
        if (bus.wen_ext) mem[bus.addr_ext[8:2]] <= bus.wdata_ext;
        if (bus.ren_ext) bus.rdata_ext <= mem[bus.addr_ext[8:2]] ^
                                          ((corrupt && bus.addr_ext == 64'h4) ? 32'h1 : 32'h0);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every memory-side access must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && (bus.wen_ext || bus.ren_ext)) begin
            checkOutput("wen_ren_exclusive", 64'(bus.wen_ext & bus.ren_ext), 64'd0);
            if (bus.wen_ext) begin
                checkOutput("write_expected", 64'(wr_addr_q.size() != 0), 64'd1);
                if (wr_addr_q.size() != 0) begin
                    checkOutput("write_addr", bus.addr_ext, wr_addr_q.pop_front());
                    checkOutput("write_data", 64'(bus.wdata_ext), 64'(wr_data_q.pop_front()));
                end
            end
            if (bus.ren_ext) begin
                checkOutput("read_expected", 64'(rd_addr_q.size() != 0), 64'd1);
                if (rd_addr_q.size() != 0) begin
                    checkOutput("read_addr", bus.addr_ext, rd_addr_q.pop_front());
                end
            end
        end
    end

    task automatic streamWords(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            w = (k < 3) ? img[k] : $urandom();
            wr_addr_q.push_back(64'(k) * 64'd4);
            wr_data_q.push_back(w);
            bus.s_valid = 1'b1;
            bus.s_data  = w;
            tick();
            bus.s_valid = 1'b0;
            if (k < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic waitDone(input int exp_lat);
        int lat;
        lat = 0;
        while (!cpu_enable && !error && lat < 400) begin
            tick();
            lat++;
        end
        checkOutput("done_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic applyStimulus(input vec_t v);
        bit ok;
        ok        = (v.n >= 1) && (v.n <= 128);
        corrupt   = v.corrupt;
        num_words = 8'(v.n);
        if (ok) begin
            for (int k = 0; k < v.n; k++) rd_addr_q.push_back(64'(k) * 64'd4);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!ok) begin
            checkOutput("len_error", 64'(error), 64'd1);
            checkOutput("len_code", 64'(err_code), 64'(ERR_LEN));
            checkOutput("len_busy", 64'(busy), 64'd0);
            checkOutput("len_s_ready", 64'(bus.s_ready), 64'd0);
        end else begin
            checkOutput("load_s_ready", 64'(bus.s_ready), 64'd1);
            checkOutput("load_busy", 64'(busy), 64'd1);
            streamWords(v.n, v.gap);
            checkOutput("s_ready_after_last", 64'(bus.s_ready), 64'd0);
            waitDone(v.n + 3);
            checkOutput("end_cpu_enable", 64'(cpu_enable), 64'(v.exp_run));
            checkOutput("end_error", 64'(error), 64'(!v.exp_run));
            checkOutput("end_err_code", 64'(err_code), 64'(v.exp_err));
            tick();
            tick();
            checkOutput("cpu_enable_held", 64'(cpu_enable), 64'(v.exp_run));
            checkOutput("writes_drained", 64'(wr_addr_q.size()), 64'd0);
            checkOutput("reads_drained", 64'(rd_addr_q.size()), 64'd0);
        end
        corrupt = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        checkOutput("abort_cpu_enable", 64'(cpu_enable), 64'd0);
        checkOutput("abort_error", 64'(error), 64'd0);
        checkOutput("abort_err_code", 64'(err_code), 64'd0);
    endtask

    initial begin
        img[0] = 32'h00500093;
        img[1] = 32'h00100113;
        img[2] = 32'h002081B3;
        vecs[0] = '{3,   0, 1'b0, 1'b1, 2'd0};
        vecs[1] = '{3,   2, 1'b0, 1'b1, 2'd0};
        vecs[2] = '{3,   0, 1'b1, 1'b0, 2'd2};
        vecs[3] = '{0,   0, 1'b0, 1'b0, 2'd1};
        vecs[4] = '{129, 0, 1'b0, 1'b0, 2'd1};
        vecs[5] = '{1,   0, 1'b0, 1'b1, 2'd0};
        vecs[6] = '{128, 0, 1'b0, 1'b1, 2'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0; corrupt = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        tick();
        tick();
        checkOutput("rst_s_ready", 64'(bus.s_ready), 64'd0);
        checkOutput("rst_wen", 64'(bus.wen_ext), 64'd0);
        checkOutput("rst_ren", 64'(bus.ren_ext), 64'd0);
        checkOutput("rst_addr", bus.addr_ext, 64'd0);
        checkOutput("rst_wdata", 64'(bus.wdata_ext), 64'd0);
        checkOutput("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_err_code", 64'(err_code), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Abort after two of four words; the word offered alongside abort must not be written.
        num_words = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        streamWords(2, 0);
        abort = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 32'hDEADBEEF;
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        checkOutput("abort_load_s_ready", 64'(bus.s_ready), 64'd0);
        checkOutput("abort_load_error", 64'(error), 64'd1);
        checkOutput("abort_load_code", 64'(err_code), 64'(ERR_ABORT));
        checkOutput("abort_load_busy", 64'(busy), 64'd0);
        checkOutput("abort_load_wen", 64'(bus.wen_ext), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_load_to_idle", 64'(error), 64'd0);

        // Reset in the middle of readback.
        num_words = 8'd3;
        for (int k = 0; k < 3; k++) rd_addr_q.push_back(64'(k) * 64'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        streamWords(3, 0);
        tick();
        tick();
        checkOutput("vrd_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_ren", 64'(bus.ren_ext), 64'd0);
        checkOutput("midrst_wen", 64'(bus.wen_ext), 64'd0);
        checkOutput("midrst_addr", bus.addr_ext, 64'd0);
        checkOutput("midrst_wdata", 64'(bus.wdata_ext), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        checkOutput("midrst_cpu_enable", 64'(cpu_enable), 64'd0);
        checkOutput("midrst_error", 64'(error), 64'd0);
        checkOutput("midrst_err_code", 64'(err_code), 64'd0);
        rst = 1'b0;
        rd_addr_q.delete();
        tick();

        num_words = 8'd1;
        rd_addr_q.push_back(64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        streamWords(1, 0);
        waitDone(4);
        checkOutput("post_rst_run", 64'(cpu_enable), 64'd1);

        // start is ignored in RUN, abort drops back to IDLE.
        num_words = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("run_no_wen", 64'(bus.wen_ext), 64'd0);
            checkOutput("run_no_ren", 64'(bus.ren_ext), 64'd0);
            checkOutput("run_cpu_enable", 64'(cpu_enable), 64'd1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("run_abort_cpu", 64'(cpu_enable), 64'd0);
        checkOutput("run_abort_busy", 64'(busy), 64'd0);
        checkOutput("run_abort_error", 64'(error), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the pipelined CPU.
- Takes a program as a valid/ready stream of 32-bit words and writes it into instruction memory through the CPU's external port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext).
- Reads the image back and checks it against a running checksum.
- On a passing check, asserts the CPU's enable and holds it.

Parameters:
- ADDR_W, 64: width of addr_ext.
- DATA_W, 32: instruction word width.
- WORD_BYTES, 4: byte address increment per word.
- MAX_WORDS, 128: capacity of instruction memory (512 bytes).
- CNT_W, 8: width of num_words and the internal word counters; must satisfy 2^CNT_W > MAX_WORDS.
- VERIFY, 1: 1 enables the readback/checksum phase; 0 goes from LOAD straight to RUN.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a load.
- abort, input, 1: one-cycle pulse that returns the block to IDLE.
- num_words, input, CNT_W: number of words in the image, sampled with start.
- s_valid, input, 1: stream word valid.
- s_ready, output, 1: loader accepts a word this cycle.
- s_data, input, DATA_W: stream word.
- addr_ext, output, ADDR_W: instruction memory byte address.
- wen_ext, output, 1: instruction memory write enable.
- ren_ext, output, 1: instruction memory read enable.
- wdata_ext, output, DATA_W: instruction memory write word.
- rdata_ext, input, DATA_W: instruction memory read word, valid one cycle after ren_ext.
- cpu_enable, output, 1: drives the CPU's enable input.
- busy, output, 1: high in LOAD, VRD and VCHK.
- error, output, 1: high in FAIL.
- err_code, output, 2: 1 = bad length, 2 = checksum mismatch, 3 = aborted.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- While rst is sampled high: state = IDLE, and every output, counter and accumulator is 0. Reset at any point in any operation takes effect at that clock edge.
- All memory-side outputs are registered.
- IDLE:
  - On start with 1 <= num_words <= MAX_WORDS: latch N = num_words, clear idx and the checksum, go to LOAD.
  - On start with any other num_words: go to FAIL with err_code = 1.
- LOAD:
  - s_ready = 1 for as long as the block is in LOAD. One word per cycle is sustained.
  - A handshake (s_valid & s_ready) at edge t produces, in cycle t+1: wen_ext = 1, addr_ext = idx*WORD_BYTES, wdata_ext = s_data. At the same edge, idx increments and sum += s_data (mod 2^32).
  - The handshake that makes idx = N moves to VRD if VERIFY = 1, otherwise to RUN. s_ready is 0 in the cycle after that last handshake.
  - Cycles with no handshake produce wen_ext = 0.
- VRD (readback):
  - For rdx = 0..N-1, assert ren_ext with addr_ext = rdx*4, one address per cycle.
  - rdata_ext is accumulated into rsum one cycle after each read.
  - After the final read issue, wait one cycle for its data, then go to VCHK.
- VCHK: lasts one cycle. If rsum == sum go to RUN, otherwise go to FAIL with err_code = 2.
- RUN: cpu_enable = 1. start is ignored. abort sets cpu_enable = 0 and returns to IDLE.
- FAIL:
  - error = 1 and cpu_enable = 0.
  - start re-evaluates num_words exactly as in IDLE.
  - abort returns to IDLE and clears error.
- abort in LOAD, VRD or VCHK: go to FAIL with err_code = 3. s_ready, wen_ext and ren_ext are 0 from the next cycle. Words already written stay in memory.
- Priority within one cycle: rst > abort > start > handshake.
- Address arithmetic is ADDR_W wide and zero-extended from idx. idx never exceeds N, so the address never wraps.
- wen_ext and ren_ext are never high in the same cycle.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum {IDLE, LOAD, VRD, VCHK, RUN, FAIL};
  - the err_code constants ERR_LEN = 1, ERR_SUM = 2, ERR_ABORT = 3;
  - WORD_BYTES.
- One sub-module, boot_checksum: a DATA_W modular accumulator with clr and add_en inputs. It is instantiated twice, once for sum and once for rsum.

Test Plan:
- Basic load: start, num_words = 3, stream 0x00500093, 0x00100113, 0x002081B3 with s_valid held high -> wen_ext pulses at addresses 0x0, 0x4, 0x8 in three consecutive cycles; then three ren_ext reads; cpu_enable = 1 six cycles after the last write.
- Bubbles: same image with s_valid deasserted for 2 cycles between words -> wen_ext low in the gap cycles, addresses still 0x0/0x4/0x8, and the block reaches RUN.
- Corrupt readback: the memory model flips bit 0 of word 1 on read -> err_code = 2, error = 1, cpu_enable stays 0.
- Bad length: start with num_words = 0, then with num_words = 129 -> FAIL with err_code = 1 the next cycle, no wen_ext.
- Abort and reset: abort after 2 of 4 words -> err_code = 3, s_ready = 0 the next cycle. Separately, rst mid-VRD -> all outputs 0 after one edge, and a subsequent start of 1 word succeeds.
- RUN behaviour: start pulsed while in RUN -> no memory traffic. Then abort -> cpu_enable = 0 the next cycle, state IDLE.
